// File: rtl/fifo_line_buffer_pkg.sv
// Shared sizing constants for the line-buffer FIFO and its pointer synchronizers.
package fifo_line_buffer_pkg;

    localparam int unsigned FLB_DATA_WIDTH       = 8;
    localparam int unsigned FLB_ADDR_WIDTH       = 12;
    localparam int unsigned FLB_ALMOST_FULL_NUM  = 4092;
    localparam int unsigned FLB_ALMOST_EMPTY_NUM = 4;

endpackage

// File: rtl/fifo_ptr_sync.sv
// Carries a binary FIFO pointer into another clock domain: binary->Gray in the
// source domain, 2-flop synchronizer in the destination, Gray->binary after it.
module fifo_ptr_sync
    import fifo_line_buffer_pkg::*;
#(
    parameter int unsigned PTR_WIDTH = FLB_ADDR_WIDTH + 1
) (
    input  logic                 i_src_clk,
    input  logic                 i_src_rst,
    // next-state pointer, so the Gray copy is aligned with the pointer register
    input  logic [PTR_WIDTH-1:0] i_src_bin,
    input  logic                 i_dst_clk,
    input  logic                 i_dst_rst,
    output logic [PTR_WIDTH-1:0] o_dst_bin
);

    logic [PTR_WIDTH-1:0] r_src_gray;
    logic [PTR_WIDTH-1:0] r_sync1;
    logic [PTR_WIDTH-1:0] r_sync2;
    logic [PTR_WIDTH-1:0] w_dst_bin;

    // Register the Gray-coded pointer in the source domain (glitch-free crossing)
    always_ff @(posedge i_src_clk or posedge i_src_rst) begin
        if (i_src_rst) r_src_gray <= '0;
        else           r_src_gray <= i_src_bin ^ (i_src_bin >> 1);
    end

    // Two-flop synchronizer in the destination domain
    always_ff @(posedge i_dst_clk or posedge i_dst_rst) begin
        if (i_dst_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= r_src_gray;
            r_sync2 <= r_sync1;
        end
    end

    // Gray->binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_dst_bin = '0;
        for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
            w_dst_bin = w_dst_bin ^ (r_sync2 >> i);
        end
    end

    assign o_dst_bin = w_dst_bin;

endmodule

// File: rtl/fifo_line_buffer.sv
// Dual-clock line-buffer FIFO, standard (non-FWFT) read, registered flags.
// Flags are computed from the next pointer so they change on the causing edge;
// the opposite-domain pointer is stale, which only makes the flags pessimistic.
module fifo_line_buffer
    import fifo_line_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = FLB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH       = FLB_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL_NUM  = FLB_ALMOST_FULL_NUM,
    parameter int unsigned ALMOST_EMPTY_NUM = FLB_ALMOST_EMPTY_NUM
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty
);

    localparam int unsigned         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH:0]   r_wr_bin;
    logic [ADDR_WIDTH:0]   w_wr_bin_next;
    logic [ADDR_WIDTH:0]   w_rd_bin_at_wr;
    logic [ADDR_WIDTH:0]   w_wr_fill_next;
    logic                  w_wr_push;
    logic                  r_wr_full;
    logic                  r_almost_full;

    logic [ADDR_WIDTH:0]   r_rd_bin;
    logic [ADDR_WIDTH:0]   w_rd_bin_next;
    logic [ADDR_WIDTH:0]   w_wr_bin_at_rd;
    logic [ADDR_WIDTH:0]   w_rd_fill_next;
    logic                  w_rd_pop;
    logic                  r_rd_empty;
    logic                  r_almost_empty;
    logic [DATA_WIDTH-1:0] r_rd_data;

    assign w_wr_push      = wr_en && !r_wr_full;
    assign w_wr_bin_next  = r_wr_bin + {{ADDR_WIDTH{1'b0}}, w_wr_push};
    assign w_wr_fill_next = w_wr_bin_next - w_rd_bin_at_wr;

    assign w_rd_pop       = rd_en && !r_rd_empty;
    assign w_rd_bin_next  = r_rd_bin + {{ADDR_WIDTH{1'b0}}, w_rd_pop};
    assign w_rd_fill_next = w_wr_bin_at_rd - w_rd_bin_next;

    fifo_ptr_sync #(.PTR_WIDTH(ADDR_WIDTH + 1)) u_wr2rd_sync (
        .i_src_clk (wr_clk),
        .i_src_rst (wr_rst),
        .i_src_bin (w_wr_bin_next),
        .i_dst_clk (rd_clk),
        .i_dst_rst (rd_rst),
        .o_dst_bin (w_wr_bin_at_rd)
    );

    fifo_ptr_sync #(.PTR_WIDTH(ADDR_WIDTH + 1)) u_rd2wr_sync (
        .i_src_clk (rd_clk),
        .i_src_rst (rd_rst),
        .i_src_bin (w_rd_bin_next),
        .i_dst_clk (wr_clk),
        .i_dst_rst (wr_rst),
        .o_dst_bin (w_rd_bin_at_wr)
    );

    // Write-domain pointer and full/almost-full flags
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_wr_bin      <= '0;
            r_wr_full     <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_wr_bin      <= w_wr_bin_next;
            r_wr_full     <= (w_wr_fill_next == FULL_CNT);
            r_almost_full <= (w_wr_fill_next >= AF_CNT);
        end
    end

    // RAM write port (contents are never cleared)
    always_ff @(posedge wr_clk) begin
        if (w_wr_push) r_mem[r_wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
    end

    // Read-domain pointer and empty/almost-empty flags
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_rd_bin       <= '0;
            r_rd_empty     <= 1'b1;
            r_almost_empty <= 1'b1;
        end else begin
            r_rd_bin       <= w_rd_bin_next;
            r_rd_empty     <= (w_rd_fill_next == '0);
            r_almost_empty <= (w_rd_fill_next <= AE_CNT);
        end
    end

    // RAM read port: popped word lands one cycle after rd_en, else holds
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)        r_rd_data <= '0;
        else if (w_rd_pop) r_rd_data <= r_mem[r_rd_bin[ADDR_WIDTH-1:0]];
    end

    assign wr_full      = r_wr_full;
    assign almost_full  = r_almost_full;
    assign rd_empty     = r_rd_empty;
    assign almost_empty = r_almost_empty;
    assign rd_data      = r_rd_data;

endmodule

// File: tb/tb_fifo_line_buffer.sv
// Directed bench for fifo_line_buffer with a single shared clock and reset.
module tb_fifo_line_buffer;

    logic       clk;
    logic       tb_rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_full;
    logic       almost_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic       almost_empty;

    int n_vec;
    int n_fail;

    fifo_line_buffer #(
        .DATA_WIDTH       (8),
        .ADDR_WIDTH       (12),
        .ALMOST_FULL_NUM  (4092),
        .ALMOST_EMPTY_NUM (4)
    ) dut (
        .wr_clk       (clk),
        .wr_rst       (tb_rst),
        .rd_clk       (clk),
        .rd_rst       (tb_rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_full      (wr_full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_empty     (rd_empty),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        int         drop_cycle;

        n_vec   = 0;
        n_fail  = 0;
        tb_rst  = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;

        // Reset state
        repeat (3) step();
        check("rst_rd_empty",     32'(rd_empty),     32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_wr_full",      32'(wr_full),      32'd0);
        check("rst_almost_full",  32'(almost_full),  32'd0);
        check("rst_rd_data",      32'(rd_data),      32'h0);
        tb_rst = 1'b0;
        repeat (4) step();

        // Fill: 4097 decrementing words, last one must be dropped
        for (int i = 0; i < 4097; i++) begin
            wr_data = 8'(8'hFF - 8'(i));
            wr_en   = 1'b1;
            step();
            check($sformatf("fill_af_%0d", i + 1),   32'(almost_full), 32'((i + 1) >= 4092));
            check($sformatf("fill_full_%0d", i + 1), 32'(wr_full),     32'((i + 1) >= 4096));
        end
        wr_en = 1'b0;
        repeat (4) step();
        check("filled_rd_empty",     32'(rd_empty),     32'd0);
        check("filled_almost_empty", 32'(almost_empty), 32'd0);

        // Drain: 4096 reads, data FF..00 sixteen times
        for (int i = 0; i < 4096; i++) begin
            rd_en = 1'b1;
            step();
            exp_d = 8'(8'hFF - 8'(i));
            check($sformatf("drain_data_%0d", i),  32'(rd_data),      32'(exp_d));
            check($sformatf("drain_ae_%0d", i),    32'(almost_empty), 32'((4095 - i) <= 4));
            check($sformatf("drain_empty_%0d", i), 32'(rd_empty),     32'((4095 - i) == 0));
        end

        // Read while empty: ignored, data holds
        step();
        check("empty_rd_data",  32'(rd_data),  32'h00);
        check("empty_rd_empty", 32'(rd_empty), 32'd1);
        rd_en = 1'b0;
        repeat (4) step();
        check("drained_wr_full",     32'(wr_full),     32'd0);
        check("drained_almost_full", 32'(almost_full), 32'd0);

        // Single write then read: empty drops within 3 cycles
        wr_data = 8'h5A;
        wr_en   = 1'b1;
        step();
        wr_en      = 1'b0;
        drop_cycle = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (drop_cycle == 0 && rd_empty == 1'b0) drop_cycle = k;
        end
        check("single_empty_drop", 32'(drop_cycle != 0), 32'd1);
        check("single_almost_empty", 32'(almost_empty), 32'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("single_rd_data",  32'(rd_data),  32'h5A);
        check("single_rd_empty", 32'(rd_empty), 32'd1);

        // Build fill count of 100 (data 0..99)
        for (int j = 0; j < 100; j++) begin
            wr_data = 8'(j);
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        repeat (4) step();
        check("f100_rd_empty",     32'(rd_empty),     32'd0);
        check("f100_almost_empty", 32'(almost_empty), 32'd0);
        check("f100_wr_full",      32'(wr_full),      32'd0);
        check("f100_almost_full",  32'(almost_full),  32'd0);

        // 50 cycles of simultaneous read/write
        for (int k = 0; k < 50; k++) begin
            wr_data = 8'(100 + k);
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            step();
            check($sformatf("rw_data_%0d", k), 32'(rd_data), 32'(k));
            check($sformatf("rw_flags_%0d", k),
                  {28'd0, rd_empty, almost_empty, wr_full, almost_full}, 32'h0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (4) step();

        // Drain remaining 100: words 50..149 in order, empty only after last
        for (int k = 0; k < 100; k++) begin
            rd_en = 1'b1;
            step();
            check($sformatf("rw_drain_data_%0d", k),  32'(rd_data),  32'(50 + k));
            check($sformatf("rw_drain_empty_%0d", k), 32'(rd_empty), 32'(k == 99));
        end
        rd_en = 1'b0;

        // Mid-operation reset discards contents
        for (int j = 0; j < 3; j++) begin
            wr_data = 8'hC0 + 8'(j);
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        repeat (4) step();
        check("pre_rst_rd_empty", 32'(rd_empty), 32'd0);
        tb_rst = 1'b1;
        step();
        tb_rst = 1'b0;
        repeat (5) step();
        check("post_rst_rd_empty",     32'(rd_empty),     32'd1);
        check("post_rst_almost_empty", 32'(almost_empty), 32'd1);
        check("post_rst_rd_data",      32'(rd_data),      32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
